// File: rtl/nonce_tx_pkg.sv
// Shared types and constants for the nonce shift-out block.
// Build option: NONCE_TX_HASH_EN appends the 256-bit hash to each frame.
package nonce_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [7:0] HDR_NONCE       = 8'hA5;
  localparam logic [7:0] HDR_NONCE_HASH  = 8'hA6;
  localparam int         FRAME_LEN_NONCE = 5;
  localparam int         FRAME_LEN_HASH  = 37;
  localparam int         IDX_W           = 6;

`ifdef NONCE_TX_HASH_EN
  localparam int         FRAME_LEN = FRAME_LEN_HASH;
  localparam logic [7:0] FRAME_HDR = HDR_NONCE_HASH;
  localparam int         HOLD_W    = 288;
`else
  localparam int         FRAME_LEN = FRAME_LEN_NONCE;
  localparam logic [7:0] FRAME_HDR = HDR_NONCE;
  localparam int         HOLD_W    = 32;
`endif

endpackage

// File: rtl/nonce_shift_out_counter.sv
// Generic up-counter with synchronous clear and rollover at a fixed terminal value.
module nonce_shift_out_counter #(
  parameter int               WIDTH    = 6,
  parameter logic [WIDTH-1:0] ROLLOVER = '1
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic             at_max
);

  logic [WIDTH-1:0] count_reg;
  logic [WIDTH-1:0] count_next;

  always_comb begin
    count_next = count_reg;
    if (clr) begin
      count_next = '0;
    end else if (en) begin
      count_next = (count_reg == ROLLOVER) ? '0 : count_reg + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  assign count  = count_reg;
  assign at_max = (count_reg == ROLLOVER);

endmodule

// File: rtl/nonce_shift_out.sv
// Serialises a winning nonce (and optionally its hash) into a byte stream with valid/ready.
// Build option: NONCE_TX_HASH_EN selects 37-byte nonce+hash frames instead of 5-byte nonce frames.
module nonce_shift_out
  import nonce_tx_pkg::*;
(
  input  logic         clk,
  input  logic         n_rst,
  input  logic         start_found,
  input  logic [31:0]  found_nonce,
  input  logic [255:0] found_hash,
  input  logic         abort,
  input  logic         tx_ready,
  output logic [7:0]   tx_data,
  output logic         tx_valid,
  output logic         tx_last,
  output logic         busy,
  output logic         send_done,
  output logic         overrun
);

  localparam int FRAME_W = FRAME_LEN * 8;

  state_e              state_reg, state_next;
  logic [HOLD_W-1:0]   hold_reg, hold_next;
  logic                overrun_reg, overrun_next;
  logic [HOLD_W-1:0]   capture;
  logic [IDX_W-1:0]    byte_idx;
  logic                idx_at_last;
  logic                in_send;
  logic                transfer;
  logic                accept;
  logic                idx_clr;
  logic [FRAME_W-1:0]  frame_vec;
  logic [7:0]          frame_bytes [FRAME_LEN];
  logic [7:0]          byte_sel;

`ifdef NONCE_TX_HASH_EN
  assign capture = {found_nonce, found_hash};
`else
  logic unused_hash;
  assign unused_hash = ^found_hash;
  assign capture     = found_nonce;
`endif

  assign in_send  = (state_reg == ST_SEND);
  assign transfer = in_send && tx_ready;
  // Abort wins over a coincident start, so the nonce is never captured then.
  assign accept   = start_found && !abort && !in_send;
  assign idx_clr  = abort || accept;

  nonce_shift_out_counter #(
    .WIDTH    (IDX_W),
    .ROLLOVER (IDX_W'(FRAME_LEN - 1))
  ) u_byte_idx (
    .clk    (clk),
    .n_rst  (n_rst),
    .clr    (idx_clr),
    .en     (transfer),
    .count  (byte_idx),
    .at_max (idx_at_last)
  );

  assign frame_vec = {FRAME_HDR, hold_reg};

  generate
    for (genvar gi = 0; gi < FRAME_LEN; gi++) begin : g_bytes
      assign frame_bytes[gi] = frame_vec[FRAME_W-1-8*gi -: 8];
    end
  endgenerate

  always_comb begin
    byte_sel = 8'h00;
    for (int i = 0; i < FRAME_LEN; i++) begin
      if (byte_idx == IDX_W'(i)) begin
        byte_sel = frame_bytes[i];
      end
    end
  end

  always_comb begin
    state_next   = state_reg;
    hold_next    = hold_reg;
    overrun_next = overrun_reg;
    if (abort) begin
      state_next   = ST_IDLE;
      overrun_next = 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE, ST_DONE: begin
          if (start_found) begin
            state_next = ST_SEND;
            hold_next  = capture;
          end else begin
            state_next = ST_IDLE;
          end
        end
        ST_SEND: begin
          // A second nonce mid-frame is dropped; only the flag records it.
          if (start_found) begin
            overrun_next = 1'b1;
          end
          if (transfer && idx_at_last) begin
            state_next = ST_DONE;
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_reg   <= ST_IDLE;
      hold_reg    <= '0;
      overrun_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      hold_reg    <= hold_next;
      overrun_reg <= overrun_next;
    end
  end

  assign tx_valid  = in_send;
  assign tx_data   = in_send ? byte_sel : 8'h00;
  assign tx_last   = in_send && idx_at_last;
  assign busy      = in_send;
  assign send_done = (state_reg == ST_DONE);
  assign overrun   = overrun_reg;

endmodule

// File: doc/nonce_shift_out.md
NONCE_SHIFT_OUT -- requirements
Module: nonce_shift_out

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state changes on its rising edge.
REQ-002 SHALL have port n_rst, input, 1, reset, asynchronous and active-low.
REQ-003 SHALL have port start_found, input, 1, single-cycle pulse: a winning nonce is present on found_nonce/found_hash.
REQ-004 SHALL have port found_nonce, input, 32, the winning nonce, sampled only when start_found is accepted.
REQ-005 SHALL have port found_hash, input, 256, the winning hash (word 0 in bits 255:224), sampled with found_nonce; ignored when NONCE_TX_HASH_EN is undefined.
REQ-006 SHALL have port abort, input, 1, synchronous clear from the mining controller.
REQ-007 SHALL have port tx_ready, input, 1, host sink accepts the byte this cycle.
REQ-008 SHALL have port tx_data, output, 8, current frame byte.
REQ-009 SHALL have port tx_valid, output, 1, tx_data is valid.
REQ-010 SHALL have port tx_last, output, 1, high with tx_valid on the final frame byte.
REQ-011 SHALL have port busy, output, 1, high while in SEND.
REQ-012 SHALL have port send_done, output, 1, one-cycle pulse after the last byte transfers.
REQ-013 SHALL have port overrun, output, 1, sticky flag: a start_found was dropped.

Function
REQ-014 SHALL implement states IDLE, SEND and DONE.
REQ-015 Frame SHALL be: header byte, then found_nonce MSB first, then (macro on) found_hash MSB first.
REQ-016 Frame length SHALL be 5 bytes (macro off) or 37 bytes (macro on); the byte index counter is 6 bits and wraps to 0 at frame end.
REQ-017 start_found in IDLE or DONE SHALL capture nonce/hash into a holding register, clear the byte index and enter SEND; tx_valid rises the next cycle carrying the header.
REQ-018 A transfer SHALL occur iff tx_valid && tx_ready; the byte index advances by exactly one per transfer.
REQ-019 While tx_valid && !tx_ready, tx_data, tx_last and the byte index SHALL hold stable.
REQ-020 tx_valid SHALL stay high throughout SEND; no bubbles are inserted between bytes.
REQ-021 Transfer of the byte with tx_last SHALL move the block to DONE; DONE SHALL assert send_done for exactly one cycle, then move to IDLE unless start_found is present.
REQ-022 start_found during SEND SHALL be dropped, SHALL NOT disturb the frame in flight, and SHALL set overrun.
REQ-023 abort SHALL force IDLE from any state on the next edge: tx_valid low, byte index 0, overrun cleared, no send_done.
REQ-024 abort and start_found in the same cycle SHALL resolve as abort; the nonce is not captured.
REQ-025 busy SHALL be high exactly in SEND; tx_last SHALL never be high without tx_valid.

Reset
REQ-026 n_rst low SHALL immediately force IDLE, tx_valid=0, tx_last=0, busy=0, send_done=0, overrun=0, tx_data=0x00, byte index 0 and holding register 0.
REQ-027 Release of n_rst SHALL be safe at any edge; the first start_found is honoured on the first active cycle.

Configuration
REQ-028 Macro NONCE_TX_HASH_EN defined SHALL give 37-byte frames with header 0xA6 and a 288-bit holding register.
REQ-029 Macro NONCE_TX_HASH_EN undefined SHALL give 5-byte frames with header 0xA5 and a 32-bit holding register; found_hash is unused.

Structure
REQ-030 Package nonce_tx_pkg SHALL hold the state enum, HDR_NONCE (0xA5), HDR_NONCE_HASH (0xA6), FRAME_LEN_NONCE (5) and FRAME_LEN_HASH (37).
REQ-031 The byte index SHALL be an instance of the team's generic counter module (6-bit, rollover at frame length minus 1); no other sub-modules.

Verification
REQ-032 Macro off, tx_ready=1, start_found with nonce 0xDEADBEEF -> bytes A5 DE AD BE EF on 5 consecutive cycles, tx_last on EF, send_done pulse next cycle.
REQ-033 Macro on, nonce 0x00000001, hash word0 0x01234567 -> byte 0 is A6, bytes 1-4 are 00 00 00 01, bytes 5-8 are 01 23 45 67, tx_last on byte 36.
REQ-034 tx_ready low for 3 cycles at byte 2 -> tx_data holds 0xAD for all 3 cycles; no byte is skipped or duplicated.
REQ-035 start_found again at byte 3 -> the frame completes unchanged and overrun=1 until abort or reset.
REQ-036 abort at byte 2 with start_found in the same cycle -> tx_valid=0 next cycle, IDLE, no send_done, overrun=0.
REQ-037 n_rst pulsed low mid-frame -> all outputs 0 asynchronously; a fresh start_found afterwards yields a complete frame.
